mc_control: RTL
===============

// Module: mc_control
// PURPOSE
//  Multi-cycle main control FSM for the MIPS datapath (shared memory, IR, A/B/ALUOut regs).
//  Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB, drives all datapath selects and
//  write strobes, and resolves beq/bne. Waits on a memory ready handshake; counts retired instrs.
// PARAMETERS
//  CNT_W       32   width of retired-instruction counter
// PORTS
//  clk          in   1      clock, rising edge
//  rst_n        in   1      asynchronous, active-low reset
//  op           in   6      opcode from IR[31:26]; stable from DECODE onward
//  zero         in   1      main ALU zero flag
//  mem_ready    in   1      memory access completes this cycle
//  pc_write     out  1      load PC (includes resolved branch condition)
//  ir_write     out  1      load instruction register
//  i_or_d       out  1      mem addr: 0=PC, 1=ALUOut
//  mem_read     out  1      memory read strobe
//  mem_write    out  1      memory write strobe
//  mem_to_reg   out  1      RF write data: 0=ALUOut, 1=MDR
//  reg_dst      out  1      RF write reg: 0=rt, 1=rd
//  reg_write    out  1      RF write enable
//  alu_src_a    out  1      ALU A: 0=PC, 1=reg A
//  alu_src_b    out  2      ALU B: 00=reg B, 01=const 1, 10=sign-ext imm, 11=imm<<2
//  alu_op       out  3      000=add, 001=sub, 010=R-type (funct decides)
//  pc_src       out  2      next PC: 00=ALU result, 01=ALUOut, 10=jump addr
//  state        out  4      current FSM state (debug)
//  illegal      out  1      one-cycle pulse: undefined opcode seen in DECODE
//  instr_count  out  CNT_W  instructions retired since reset
// BEHAVIOUR
//  States: FETCH=0 DECODE=1 MADDR=2 MRD=3 MWB=4 MWR=5 EXEC=6 RWB=7 BR=8 JMP=9 IEXEC=10 IWB=11.
//  Reset (async, rst_n=0): state=FETCH, instr_count=0, illegal=0, ALL strobes (pc_write,
//   ir_write, mem_read, mem_write, reg_write) forced 0 while rst_n low; selects = 0.
//   Reset mid-instruction abandons it, no count; first FETCH after the first clk edge post-release.
//  Outputs are Moore (decoded from state) except pc_write/ir_write gated by mem_ready/zero.
//  FETCH: mem_read=1,i_or_d=0,alu_src_a=0,alu_src_b=01,alu_op=add,pc_src=00;
//   ir_write=pc_write=mem_ready. Stay while !mem_ready; mem_ready -> DECODE.
//  DECODE: alu_src_a=0,alu_src_b=11,alu_op=add (branch target into ALUOut). By op:
//   0x00->EXEC, 0x23/0x2B->MADDR, 0x04/0x05->BR, 0x02->JMP, 0x08->IEXEC;
//   other -> FETCH with illegal=1 next cycle, instruction not counted.
//  MADDR: a=1,b=10,add. op 0x23->MRD, 0x2B->MWR.
//  MRD: mem_read=1,i_or_d=1; hold until mem_ready -> MWB.
//  MWB: reg_write=1,mem_to_reg=1,reg_dst=0 -> FETCH, retire.
//  MWR: mem_write=1,i_or_d=1; hold (write asserted) until mem_ready -> FETCH, retire.
//  EXEC: a=1,b=00,alu_op=010 -> RWB.  RWB: reg_write=1,reg_dst=1,mem_to_reg=0 -> FETCH, retire.
//  IEXEC: a=1,b=10,add -> IWB.  IWB: reg_write=1,reg_dst=0,mem_to_reg=0 -> FETCH, retire.
//  BR: a=1,b=00,sub,pc_src=01; pc_write=(op==0x04&zero)|(op==0x05&!zero) -> FETCH, retire.
//  JMP: pc_src=10,pc_write=1 -> FETCH, retire.
//  Retire: instr_count+=1 on the transition into FETCH; wraps 2^CNT_W-1 -> 0 silently.
//  Latency (mem_ready=1 always): R/addi 4, lw 5, sw 4, branch 3, jump 3 cycles.
//  mem_ready outside FETCH/MRD/MWR is ignored. mem_write and mem_read never both 1.
// TESTING
//  1 rst_n=0 mid-MRD -> state=0, strobes 0, instr_count=0; release -> FETCH, mem_read=1.
//  2 op=0x00, mem_ready=1 -> states 0,1,6,7,0; reg_write only in RWB, reg_dst=1; count=1.
//  3 op=0x23, mem_ready low 3 cycles in MRD -> MRD held 4 cycles, mem_read steady; lw=8 cycles.
//  4 op=0x04 zero=1 -> pc_write=1,pc_src=01 in BR; op=0x05 zero=1 -> pc_write=0; both count.
//  5 op=0x3F -> DECODE->FETCH, illegal pulses 1 cycle, instr_count unchanged.
//  6 preload CNT_W=4, run 16 jumps (op=0x02) -> instr_count wraps 15->0; pc_src=10 each JMP.

Source files
------------

// File: rtl/mc_control.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mc_control: multi-cycle MIPS main control FSM with memory-ready handshake,   |
// | branch resolution and retired-instruction counter.  Rev 1.0                  |
// +----------------------------------------------------------------------------+
module mc_control #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       op,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             ir_write,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             mem_to_reg,
  output logic             reg_dst,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [2:0]       alu_op,
  output logic [1:0]       pc_src,
  output logic [3:0]       state,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_count
);

  localparam logic [5:0] c_OP_RTYPE = 6'h00;
  localparam logic [5:0] c_OP_LW    = 6'h23;
  localparam logic [5:0] c_OP_SW    = 6'h2B;
  localparam logic [5:0] c_OP_BEQ   = 6'h04;
  localparam logic [5:0] c_OP_BNE   = 6'h05;
  localparam logic [5:0] c_OP_J     = 6'h02;
  localparam logic [5:0] c_OP_ADDI  = 6'h08;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MADDR  = 4'd2,
    S_MRD    = 4'd3,
    S_MWB    = 4'd4,
    S_MWR    = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_BR     = 4'd8,
    S_JMP    = 4'd9,
    S_IEXEC  = 4'd10,
    S_IWB    = 4'd11
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_count;
  logic             r_illegal;
  logic             w_retire;
  logic             w_bad_op;

  logic       w_pc_write, w_ir_write, w_i_or_d, w_mem_read, w_mem_write;
  logic       w_mem_to_reg, w_reg_dst, w_reg_write, w_alu_src_a;
  logic [1:0] w_alu_src_b, w_pc_src;
  logic [2:0] w_alu_op;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_FETCH;
      r_count   <= '0;
      r_illegal <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_illegal <= w_bad_op;
      if (w_retire)
        r_count <= r_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_comb begin
    w_next       = r_state;
    w_retire     = 1'b0;
    w_bad_op     = 1'b0;
    w_pc_write   = 1'b0;
    w_ir_write   = 1'b0;
    w_i_or_d     = 1'b0;
    w_mem_read   = 1'b0;
    w_mem_write  = 1'b0;
    w_mem_to_reg = 1'b0;
    w_reg_dst    = 1'b0;
    w_reg_write  = 1'b0;
    w_alu_src_a  = 1'b0;
    w_alu_src_b  = 2'b00;
    w_alu_op     = 3'b000;
    w_pc_src     = 2'b00;
    case (r_state)
      S_FETCH: begin
        w_mem_read  = 1'b1;
        w_alu_src_b = 2'b01;
        w_ir_write  = mem_ready;
        w_pc_write  = mem_ready;
        if (mem_ready) w_next = S_DECODE;
      end
      S_DECODE: begin
        // branch target is computed speculatively here into ALUOut
        w_alu_src_b = 2'b11;
        case (op)
          c_OP_RTYPE:       w_next = S_EXEC;
          c_OP_LW, c_OP_SW: w_next = S_MADDR;
          c_OP_BEQ, c_OP_BNE: w_next = S_BR;
          c_OP_J:           w_next = S_JMP;
          c_OP_ADDI:        w_next = S_IEXEC;
          default: begin
            w_next   = S_FETCH;
            w_bad_op = 1'b1;
          end
        endcase
      end
      S_MADDR: begin
        w_alu_src_a = 1'b1;
        w_alu_src_b = 2'b10;
        w_next      = (op == c_OP_LW) ? S_MRD : S_MWR;
      end
      S_MRD: begin
        w_mem_read = 1'b1;
        w_i_or_d   = 1'b1;
        if (mem_ready) w_next = S_MWB;
      end
      S_MWB: begin
        w_reg_write  = 1'b1;
        w_mem_to_reg = 1'b1;
        w_next       = S_FETCH;
        w_retire     = 1'b1;
      end
      S_MWR: begin
        w_mem_write = 1'b1;
        w_i_or_d    = 1'b1;
        if (mem_ready) begin
          w_next   = S_FETCH;
          w_retire = 1'b1;
        end
      end
      S_EXEC: begin
        w_alu_src_a = 1'b1;
        w_alu_op    = 3'b010;
        w_next      = S_RWB;
      end
      S_RWB: begin
        w_reg_write = 1'b1;
        w_reg_dst   = 1'b1;
        w_next      = S_FETCH;
        w_retire    = 1'b1;
      end
      S_IEXEC: begin
        w_alu_src_a = 1'b1;
        w_alu_src_b = 2'b10;
        w_next      = S_IWB;
      end
      S_IWB: begin
        w_reg_write = 1'b1;
        w_next      = S_FETCH;
        w_retire    = 1'b1;
      end
      S_BR: begin
        w_alu_src_a = 1'b1;
        w_alu_op    = 3'b001;
        w_pc_src    = 2'b01;
        w_pc_write  = ((op == c_OP_BEQ) && zero) || ((op == c_OP_BNE) && !zero);
        w_next      = S_FETCH;
        w_retire    = 1'b1;
      end
      S_JMP: begin
        w_pc_src   = 2'b10;
        w_pc_write = 1'b1;
        w_next     = S_FETCH;
        w_retire   = 1'b1;
      end
      default: w_next = S_FETCH;
    endcase
  end

  // Reset leaves the FSM in FETCH, whose strobes must still read 0 while rst_n is low
  assign pc_write    = rst_n & w_pc_write;
  assign ir_write    = rst_n & w_ir_write;
  assign i_or_d      = rst_n & w_i_or_d;
  assign mem_read    = rst_n & w_mem_read;
  assign mem_write   = rst_n & w_mem_write;
  assign mem_to_reg  = rst_n & w_mem_to_reg;
  assign reg_dst     = rst_n & w_reg_dst;
  assign reg_write   = rst_n & w_reg_write;
  assign alu_src_a   = rst_n & w_alu_src_a;
  assign alu_src_b   = {2{rst_n}} & w_alu_src_b;
  assign alu_op      = {3{rst_n}} & w_alu_op;
  assign pc_src      = {2{rst_n}} & w_pc_src;
  assign state       = r_state;
  assign illegal     = r_illegal;
  assign instr_count = r_count;

endmodule
`default_nettype wire
